// File: rtl/cmd_param_bank_if.sv
// Avalon-MM slave bundle for the command/parameter bank.
// The host side uses master; the register bank uses slave.
interface cmd_param_bank_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, writedata, write, read,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, writedata, write, read,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/cmd_param_bank.sv
// Multi-channel command/parameter bank: the host writes shadow parameters,
// which are committed atomically into active copies. CH_CTRL command bits
// fire as one-cycle pulses.
module cmd_param_bank #(
  parameter int N_CH        = 3,
  parameter int REGS_PER_CH = 8,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  cmd_param_bank_if.slave                        avs_s0,
  input  logic                                   syncpulse,
  input  logic                                   turn_on_rf,
  output logic [N_CH-1:0]                        ch_stop,
  output logic [N_CH-1:0]                        ch_start,
  output logic [N_CH-1:0]                        ch_start_n,
  output logic [N_CH-1:0]                        ch_dir,
  output logic [N_CH-1:0]                        ch_auto,
  output logic [N_CH*(REGS_PER_CH-1)*DATA_W-1:0] param_active,
  output logic                                   commit_pulse,
  output logic                                   irq
);
  localparam int NP = REGS_PER_CH - 1;
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [31:0] ID_VALUE = 32'h5246_0200;

  localparam logic [ADDR_W-1:0] ADDR_ID     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_GCTRL  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_COUNT  = ADDR_W'(3);

  logic [DATA_W-1:0] shadow_param [N_CH][NP];
  logic [DATA_W-1:0] active_param [N_CH][NP];
  logic [N_CH-1:0]   shadow_dir;
  logic [N_CH-1:0]   shadow_auto;

  logic              auto_sync_en;
  logic              addr_err;
  logic              pending;
  logic              status_rf;
  logic              sync_prev;
  logic [15:0]       commit_count;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wr;
  logic              rd;
  logic              hit_id;
  logic              hit_gctrl;
  logic              hit_status;
  logic              hit_count;
  logic              hit_ch;
  logic [CH_W-1:0]   ch_sel;
  logic [3:0]        reg_sel;
  logic              mapped;
  logic              err_set;
  logic              err_clr;
  logic              shadow_wr;
  logic              sync_edge;
  logic              commit_req;
  logic              do_commit;
  logic [DATA_W-1:0] rd_mux;

  assign addr  = avs_s0.address;
  assign wdata = avs_s0.writedata;
  assign wr    = avs_s0.write;
  // A write in the same cycle as a read takes the port; the read is dropped.
  assign rd    = avs_s0.read & ~avs_s0.write;

  assign avs_s0.readdata      = rdata_q;
  assign avs_s0.readdatavalid = rvalid_q;
  assign irq                  = addr_err;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves a value undefined and no latch is inferred.
  always_comb begin
    hit_id     = (addr == ADDR_ID);
    hit_gctrl  = (addr == ADDR_GCTRL);
    hit_status = (addr == ADDR_STATUS);
    hit_count  = (addr == ADDR_COUNT);
    reg_sel    = addr[3:0];
    hit_ch     = 1'b0;
    ch_sel     = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (addr[ADDR_W-1:4] == (ADDR_W-4)'(c + 1) && int'(reg_sel) < REGS_PER_CH) begin
        hit_ch = 1'b1;
        ch_sel = CH_W'(c);
      end
    end
  end

  assign mapped     = hit_id | hit_gctrl | hit_status | hit_count | hit_ch;
  assign err_set    = (rd & ~mapped) | (wr & (~mapped | hit_id | hit_count));
  assign err_clr    = wr & hit_status & wdata[0];
  assign shadow_wr  = wr & hit_ch;
  assign sync_edge  = syncpulse & ~sync_prev;
  assign commit_req = (wr & hit_gctrl & wdata[0]) | (auto_sync_en & sync_edge);
  assign do_commit  = commit_req & pending;

  always_comb begin
    rd_mux = '0;
    if (hit_id) begin
      rd_mux = DATA_W'(ID_VALUE);
    end else if (hit_gctrl) begin
      rd_mux = DATA_W'({auto_sync_en, 1'b0});
    end else if (hit_status) begin
      rd_mux = DATA_W'({status_rf, pending, addr_err});
    end else if (hit_count) begin
      rd_mux = DATA_W'(commit_count);
    end else if (hit_ch) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_sel == CH_W'(c)) begin
          if (reg_sel == 4'd0)
            rd_mux = DATA_W'({shadow_auto[c], shadow_dir[c], 3'b000});
          for (int r = 1; r < REGS_PER_CH; r++)
            if (reg_sel == 4'(r)) rd_mux = shadow_param[c][r-1];
        end
      end
    end
  end

  always_comb begin
    param_active = '0;
    for (int c = 0; c < N_CH; c++)
      for (int r = 0; r < NP; r++)
        param_active[(c*NP + r)*DATA_W +: DATA_W] = active_param[c][r];
  end

  // NOTE: state is updated only with non-blocking assignments, so every
  // right-hand side sees pre-edge values; a commit coinciding with a shadow
  // write therefore captures the old shadow contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the parameter arrays are reset explicitly, because a reset
      // must leave nothing stale to be committed later.
      for (int c = 0; c < N_CH; c++) begin
        for (int r = 0; r < NP; r++) begin
          shadow_param[c][r] <= '0;
          active_param[c][r] <= '0;
        end
      end
      shadow_dir   <= '0;
      shadow_auto  <= '0;
      ch_dir       <= '0;
      ch_auto      <= '0;
      ch_stop      <= '0;
      ch_start     <= '0;
      ch_start_n   <= '0;
      auto_sync_en <= 1'b0;
      addr_err     <= 1'b0;
      pending      <= 1'b0;
      status_rf    <= 1'b0;
      sync_prev    <= 1'b0;
      commit_count <= '0;
      commit_pulse <= 1'b0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      ch_stop      <= '0;
      ch_start     <= '0;
      ch_start_n   <= '0;
      commit_pulse <= 1'b0;
      sync_prev    <= syncpulse;
      status_rf    <= turn_on_rf;
      rvalid_q     <= rd;
      if (rd) rdata_q <= rd_mux;

      // Set wins over the W1C clear in the same cycle.
      addr_err <= err_set | (addr_err & ~err_clr);

      if (wr & hit_gctrl) auto_sync_en <= wdata[1];

      if (do_commit) begin
        for (int c = 0; c < N_CH; c++)
          for (int r = 0; r < NP; r++)
            active_param[c][r] <= shadow_param[c][r];
        ch_dir       <= shadow_dir;
        ch_auto      <= shadow_auto;
        commit_count <= commit_count + 16'd1;
        commit_pulse <= 1'b1;
      end

      if (shadow_wr) begin
        for (int c = 0; c < N_CH; c++) begin
          if (ch_sel == CH_W'(c)) begin
            if (reg_sel == 4'd0) begin
              ch_stop[c]     <= wdata[0];
              ch_start[c]    <= wdata[1];
              ch_start_n[c]  <= wdata[2];
              shadow_dir[c]  <= wdata[3];
              shadow_auto[c] <= wdata[4];
            end
            for (int r = 1; r < REGS_PER_CH; r++)
              if (reg_sel == 4'(r)) shadow_param[c][r-1] <= wdata;
          end
        end
      end

      pending <= shadow_wr | (pending & ~do_commit);
    end
  end
endmodule

// File: tb/tb_cmd_param_bank.sv
// Directed bench for cmd_param_bank: a table of register accesses plus
// hand-written sequences for commit, pulse, collision and reset corners.
module tb_cmd_param_bank;
  localparam int N_CH        = 3;
  localparam int REGS_PER_CH = 8;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 16;
  localparam int NP          = REGS_PER_CH - 1;
  localparam logic [31:0] ID_VALUE = 32'h5246_0200;

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic syncpulse = 1'b0;
  logic turn_on_rf = 1'b0;
  logic [N_CH-1:0] ch_stop, ch_start, ch_start_n, ch_dir, ch_auto;
  logic [N_CH*NP*DATA_W-1:0] param_active;
  logic commit_pulse, irq;

  int n_vec = 0;
  int n_bad = 0;
  int pulses;
  logic [31:0] rdata;
  logic        rvalid;
  vec_t        vecs[$];

  cmd_param_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cmd_param_bank #(
    .N_CH(N_CH), .REGS_PER_CH(REGS_PER_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .avs_s0(bus),
    .syncpulse(syncpulse),
    .turn_on_rf(turn_on_rf),
    .ch_stop(ch_stop),
    .ch_start(ch_start),
    .ch_start_n(ch_start_n),
    .ch_dir(ch_dir),
    .ch_auto(ch_auto),
    .param_active(param_active),
    .commit_pulse(commit_pulse),
    .irq(irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    tick();
    bus.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic v);
    bus.address = a;
    bus.read    = 1'b1;
    tick();
    bus.read    = 1'b0;
    d = bus.readdata;
    v = bus.readdatavalid;
  endtask

  function automatic logic [31:0] pw(input int idx);
    return param_active[idx*DATA_W +: DATA_W];
  endfunction

  initial begin
    bus.address = '0; bus.writedata = '0; bus.write = 1'b0; bus.read = 1'b0;

    vecs.push_back('{1'b1, 16'h10, 32'h18,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h10, 32'h0,         32'h18,       1'b0});
    vecs.push_back('{1'b0, 16'h00, 32'h0,         ID_VALUE,     1'b0});
    vecs.push_back('{1'b1, 16'h27, 32'hDEAD_BEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h27, 32'h0,         32'hDEAD_BEEF,1'b0});
    vecs.push_back('{1'b0, 16'h01, 32'h0,         32'h2,        1'b0});
    vecs.push_back('{1'b0, 16'h18, 32'h0,         32'h0,        1'b1});
    vecs.push_back('{1'b1, 16'h02, 32'h1,         32'h0,        1'b0});
    vecs.push_back('{1'b1, 16'h00, 32'h5,         32'h0,        1'b1});
    vecs.push_back('{1'b0, 16'h00, 32'h0,         ID_VALUE,     1'b1});
    vecs.push_back('{1'b1, 16'h02, 32'h1,         32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h40, 32'h0,         32'h0,        1'b1});
    vecs.push_back('{1'b1, 16'h02, 32'h1,         32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h2F, 32'h0,         32'h0,        1'b1});
    vecs.push_back('{1'b1, 16'h02, 32'h1,         32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h37, 32'h0,         32'h0,        1'b0});
    vecs.push_back('{1'b1, 16'h37, 32'h1234,      32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h37, 32'h0,         32'h1234,     1'b0});
    vecs.push_back('{1'b1, 16'h0F, 32'h1,         32'h0,        1'b1});
    vecs.push_back('{1'b1, 16'h02, 32'h0,         32'h0,        1'b1});
    vecs.push_back('{1'b1, 16'h02, 32'h1,         32'h0,        1'b0});

    repeat (2) tick();
    rst = 1'b1;

    // Reset clears shadow, outputs and counter.
    bus_write(16'h11, 32'hAAAA);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst ch_outputs", {ch_stop, ch_start, ch_start_n, ch_dir, ch_auto}, '0);
    check("rst param_active zero", 64'(param_active == '0), 64'd1);
    check("rst commit_pulse", commit_pulse, 0);
    check("rst irq", irq, 0);
    check("rst readdatavalid", bus.readdatavalid, 0);
    bus_read(16'h11, rdata, rvalid);
    check("rst shadow 0x11", rdata, 0);
    check("rst shadow 0x11 valid", rvalid, 1);
    bus_read(16'h03, rdata, rvalid);
    check("rst commit_count", rdata, 0);

    // Atomic SW commit.
    bus_write(16'h11, 32'd100);
    bus_write(16'h12, 32'd200);
    check("pre-commit p0", pw(0), 0);
    check("pre-commit p1", pw(1), 0);
    bus_read(16'h02, rdata, rvalid);
    check("pending set", rdata, 32'h2);
    bus_write(16'h01, 32'h1);
    check("commit p0", pw(0), 100);
    check("commit p1", pw(1), 200);
    check("commit pulse hi", commit_pulse, 1);
    tick();
    check("commit pulse lo", commit_pulse, 0);
    bus_read(16'h03, rdata, rvalid);
    check("count after sw commit", rdata, 1);
    bus_read(16'h02, rdata, rvalid);
    check("pending cleared", rdata, 0);

    // Sync-edge commit: a held level commits once.
    bus_write(16'h01, 32'h2);
    bus_write(16'h21, 32'd7);
    syncpulse = 1'b1;
    pulses = 0;
    repeat (5) begin tick(); pulses += int'(commit_pulse); end
    check("sync held one commit", pulses, 1);
    check("sync commit ch1 p1", pw(7), 7);
    syncpulse = 1'b0;
    tick();
    syncpulse = 1'b1;
    pulses = 0;
    repeat (3) begin tick(); pulses += int'(commit_pulse); end
    check("sync no pending no commit", pulses, 0);
    syncpulse = 1'b0;
    bus_read(16'h03, rdata, rvalid);
    check("count after sync", rdata, 2);

    // Command pulses.
    bus_write(16'h10, 32'h6);
    check("pulse start", ch_start, 3'b001);
    check("pulse start_n", ch_start_n, 3'b001);
    check("pulse stop", ch_stop, 3'b000);
    tick();
    check("pulse start end", ch_start, 3'b000);
    check("pulse start_n end", ch_start_n, 3'b000);
    bus_read(16'h10, rdata, rvalid);
    check("ctrl readback", rdata, 0);

    // Shadow write colliding with a sync commit.
    bus_write(16'h13, 32'd3);
    bus.address = 16'h13; bus.writedata = 32'd5; bus.write = 1'b1;
    syncpulse = 1'b1;
    tick();
    bus.write = 1'b0;
    syncpulse = 1'b0;
    check("collision pulse", commit_pulse, 1);
    check("collision active old", pw(2), 3);
    bus_read(16'h02, rdata, rvalid);
    check("collision pending kept", rdata, 32'h2);
    bus_write(16'h01, 32'h3);
    check("collision recommit", pw(2), 5);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rdata, rvalid);
        check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rd);
        check($sformatf("vec%0d rvalid", i), rvalid, 1);
      end
      check($sformatf("vec%0d irq", i), irq, vecs[i].exp_irq);
    end

    bus_write(16'h01, 32'h3);
    check("dir committed", ch_dir, 3'b001);
    check("auto committed", ch_auto, 3'b001);
    check("ch1 p7 committed", pw(13), 32'hDEAD_BEEF);
    check("ch2 p7 committed", pw(20), 32'h1234);

    // Address errors.
    bus_read(16'h50, rdata, rvalid);
    check("unmapped rdata", rdata, 0);
    check("unmapped rvalid", rvalid, 1);
    check("unmapped irq", irq, 1);
    tick();
    check("rvalid one cycle", bus.readdatavalid, 0);
    bus_write(16'h03, 32'h55);
    bus_read(16'h03, rdata, rvalid);
    check("count RO", rdata, 5);
    bus_write(16'h02, 32'h1);
    check("irq w1c", irq, 0);

    // SW strobe and sync edge together.
    bus_write(16'h11, 32'd9);
    bus.address = 16'h01; bus.writedata = 32'h3; bus.write = 1'b1;
    syncpulse = 1'b1;
    tick();
    bus.write = 1'b0;
    check("dual commit pulse", commit_pulse, 1);
    check("dual commit p0", pw(0), 9);
    tick();
    check("dual pulse single", commit_pulse, 0);
    syncpulse = 1'b0;
    bus_read(16'h03, rdata, rvalid);
    check("dual count", rdata, 6);

    // Write and read in the same cycle: read dropped.
    bus.address = 16'h22; bus.writedata = 32'h42; bus.write = 1'b1; bus.read = 1'b1;
    tick();
    bus.write = 1'b0; bus.read = 1'b0;
    check("wr+rd no rvalid", bus.readdatavalid, 0);
    bus_read(16'h22, rdata, rvalid);
    check("wr+rd write kept", rdata, 32'h42);

    // Back-to-back reads.
    bus.address = 16'h00; bus.read = 1'b1;
    tick();
    bus.address = 16'h03;
    check("b2b first", bus.readdata, ID_VALUE);
    check("b2b first valid", bus.readdatavalid, 1);
    tick();
    bus.read = 1'b0;
    check("b2b second", bus.readdata, 6);
    check("b2b second valid", bus.readdatavalid, 1);
    tick();
    check("b2b idle", bus.readdatavalid, 0);

    // Reset with a pending shadow write and a read in flight.
    bus_write(16'h12, 32'h55);
    bus.address = 16'h00; bus.read = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.read = 1'b0;
    check("midrst rvalid", bus.readdatavalid, 0);
    check("midrst params zero", 64'(param_active == '0), 64'd1);
    bus_write(16'h01, 32'h1);
    check("midrst no commit", commit_pulse, 0);
    bus_read(16'h03, rdata, rvalid);
    check("midrst count", rdata, 0);

    turn_on_rf = 1'b1;
    tick();
    bus_read(16'h02, rdata, rvalid);
    check("status turn_on_rf", rdata, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
